// File: rtl/reset_ready_seq_pkg.sv
// Shared types for the reset-release sequencer: FSM state encoding and counter sizing.
// Imported by the sequencer top; no logic of its own.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      RESET = 3'd0,
      WAIT  = 3'd1,
      INIT  = 3'd2,
      READY = 3'd3,
      ERROR = 3'd4
   } state_t;

   // Counter holds at most max(INIT_CYCLES, TIMEOUT_CYCLES)-1; keep at least one bit.
   function automatic int cnt_width(input int init_cycles, input int timeout_cycles);
      int m;
      m = (init_cycles > timeout_cycles) ? init_cycles : timeout_cycles;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/reset_ready_seq_if.sv
// Reset/ready handshake bundle between the sequencer (master) and the downstream datapath (slave).
// Pure wiring; no storage.
interface reset_ready_seq_if;

   logic rst_sync_n;
   logic init_req;
   logic ready;
   logic init_err;
   logic soft_rst;
   logic init_ack;

   modport master (
      output rst_sync_n,
      output init_req,
      output ready,
      output init_err,
      input  soft_rst,
      input  init_ack
   );

   modport slave (
      input  rst_sync_n,
      input  init_req,
      input  ready,
      input  init_err,
      output soft_rst,
      output init_ack
   );

endinterface

// File: rtl/reset_ready_seq_sync.sv
// Async-assert / sync-deassert reset synchroniser; release visible SYNC_STAGES edges after rst_n rises.
// No backpressure; assertion is immediate and clockless.
module reset_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic rst_sync_n
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_sync_n = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_ready_seq.sv
// Reset-release sequencer: sync reset release, settle, req/ack init handshake, then ready; ready at P(SYNC+INIT+2+ack wait).
// init_req is held until init_ack or timeout; soft_rst restarts from the settle phase.
module reset_ready_seq
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int INIT_CYCLES    = 1,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   reset_ready_seq_if.master   bus
);

   localparam int            CW        = cnt_width(INIT_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] WAIT_LOAD = CW'(INIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rst_sync_n;
   logic            init_req_q;
   logic            ready_q;
   logic            init_err_q;

   reset_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_reset_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .rst_sync_n (rst_sync_n)
   );

   // soft_rst outranks ack and timeout; RESET only waits for the synchronised release.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q != RESET && bus.soft_rst) begin
         state_d = WAIT;
         cnt_d   = WAIT_LOAD;
      end else begin
         case (state_q)
            RESET: begin
               if (rst_sync_n) begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_d = INIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            INIT: begin
               if (bus.init_ack) begin
                  state_d = READY;
                  cnt_d   = '0;
               end else if (cnt_q == TO_LAST) begin
                  state_d = ERROR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            READY: begin
               state_d = READY;
            end
            ERROR: begin
               state_d = ERROR;
            end
            default: begin
               state_d = RESET;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state into their own flops so they never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET;
         cnt_q      <= '0;
         init_req_q <= 1'b0;
         ready_q    <= 1'b0;
         init_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         init_req_q <= (state_d == INIT);
         ready_q    <= (state_d == READY);
         init_err_q <= (state_d == ERROR);
      end
   end

   assign bus.rst_sync_n = rst_sync_n;
   assign bus.init_req   = init_req_q;
   assign bus.ready      = ready_q;
   assign bus.init_err   = init_err_q;

endmodule
